// File: rtl/ldpc_ber_tester_pkg.sv
// Shared constants, types and helpers for the LLR noise injector.
// Holds the LFSR polynomial and per-lane seed derivation used by every lane.
package ldpc_ber_tester_pkg;

  localparam int          LLR_W     = 8;
  localparam int          LLR_MAX   = 127;
  localparam int          BUS_W     = 128;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] SEED_STEP = 32'h9E3779B9;

  typedef struct packed {
    logic             last;
    logic [BUS_W-1:0] dat;
  } beat_t;

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] lane_seed(logic [31:0] base, logic [31:0] idx);
    logic [31:0] s;
    s = base + idx * SEED_STEP;
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/ldpc_llr_noise_injector_if.sv
// AXI4-Stream style LLR bus: master drives data/valid/last, slave drives ready.
interface ldpc_llr_noise_injector_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ldpc_llr_noise_lane.sv
// One LLR lane: Galois LFSR noise source, arithmetic scaling, symmetric clip to +/-LLR_MAX.
// Combinational data path; the LFSR steps only when the top accepts a noisy beat.
module ldpc_llr_noise_lane
  import ldpc_ber_tester_pkg::*;
#(
  parameter logic [31:0] SEED_VAL = 32'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             step,
  input  logic             load,
  input  logic [2:0]       shift,
  input  logic [LLR_W-1:0] llr_in,
  output logic [LLR_W-1:0] llr_out,
  output logic             sat
);

  localparam logic signed [LLR_W:0] POS_LIM = (LLR_W+1)'(LLR_MAX);
  localparam logic signed [LLR_W:0] NEG_LIM = -POS_LIM;

  logic [31:0]              lfsr_q;
  logic signed [LLR_W-1:0]  raw;
  logic signed [LLR_W-1:0]  noise;
  logic signed [LLR_W:0]    sum;
  logic signed [LLR_W:0]    clip;

  always_comb begin
    raw   = lfsr_q[LLR_W-1:0];
    noise = raw >>> shift;
    sum   = $signed({llr_in[LLR_W-1], llr_in}) + $signed({noise[LLR_W-1], noise});
    if (sum > POS_LIM) begin
      clip = POS_LIM;
    end else if (sum < NEG_LIM) begin
      clip = NEG_LIM;
    end else begin
      clip = sum;
    end
    llr_out = en ? clip[LLR_W-1:0] : llr_in;
    sat     = en && (clip != sum);
  end

  // A reload wins over an advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_VAL;
    end else if (load) begin
      lfsr_q <= SEED_VAL;
    end else if (step) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

endmodule

// File: rtl/ldpc_llr_noise_injector.sv
// Adds scaled per-lane LFSR noise to a 16x8b LLR stream; one-cycle latency, one beat/cycle.
// Main + one-entry skid output stage; s_axis_tready is registered (skid empty), no path from m_axis_tready.
module ldpc_llr_noise_injector
  import ldpc_ber_tester_pkg::*;
#(
  parameter logic [31:0] SEED  = 32'h1,
  parameter int          LANES = 16
) (
  input  logic                              data_clk,
  input  logic                              data_resetn,
  input  logic                              en,
  input  logic [2:0]                        noise_shift,
  input  logic                              load_seed,
  ldpc_llr_noise_injector_if.slave          s_axis,
  ldpc_llr_noise_injector_if.master         m_axis,
  output logic [31:0]                       sat_count,
  output logic [31:0]                       frame_count
);

  localparam int PC_W = $clog2(LANES + 1);

  logic                     rdy_q;
  logic                     accept;
  logic                     step;
  logic                     out_fire;
  logic [LANES*LLR_W-1:0]   noisy;
  logic [LANES-1:0]         lane_sat;
  logic [PC_W-1:0]          sat_pc;
  logic [32:0]              sat_sum;

  beat_t                    in_beat;
  beat_t                    main_q, main_nxt;
  beat_t                    sk_q, sk_nxt;
  logic                     main_vld_q, main_vld_nxt;
  logic                     sk_vld_q, sk_vld_nxt;

  assign accept   = s_axis.tvalid && rdy_q;
  assign step     = accept && en;
  assign out_fire = main_vld_q && m_axis.tready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [31:0] LANE_SEED = lane_seed(SEED, 32'(i));
    ldpc_llr_noise_lane #(
      .SEED_VAL (LANE_SEED)
    ) u_lane (
      .clk     (data_clk),
      .rst_n   (data_resetn),
      .en      (en),
      .step    (step),
      .load    (load_seed),
      .shift   (noise_shift),
      .llr_in  (s_axis.tdata[i*LLR_W +: LLR_W]),
      .llr_out (noisy[i*LLR_W +: LLR_W]),
      .sat     (lane_sat[i])
    );
  end

  always_comb begin
    sat_pc = '0;
    for (int k = 0; k < LANES; k++) begin
      sat_pc = sat_pc + PC_W'(lane_sat[k]);
    end
    sat_sum      = {1'b0, sat_count} + 33'(sat_pc);
    in_beat.dat  = noisy;
    in_beat.last = s_axis.tlast;
  end

  // The skid is only ever filled while main is stalled and always drains first,
  // so an accept never coincides with a full skid.
  always_comb begin
    main_nxt     = main_q;
    main_vld_nxt = main_vld_q;
    sk_nxt       = sk_q;
    sk_vld_nxt   = sk_vld_q;
    if (out_fire || !main_vld_q) begin
      if (sk_vld_q) begin
        main_nxt     = sk_q;
        main_vld_nxt = 1'b1;
        sk_vld_nxt   = 1'b0;
      end else if (accept) begin
        main_nxt     = in_beat;
        main_vld_nxt = 1'b1;
      end else begin
        main_vld_nxt = 1'b0;
      end
    end else if (accept) begin
      sk_nxt     = in_beat;
      sk_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      main_q      <= '0;
      main_vld_q  <= 1'b0;
      sk_q        <= '0;
      sk_vld_q    <= 1'b0;
      rdy_q       <= 1'b0;
      sat_count   <= '0;
      frame_count <= '0;
    end else begin
      main_q     <= main_nxt;
      main_vld_q <= main_vld_nxt;
      sk_q       <= sk_nxt;
      sk_vld_q   <= sk_vld_nxt;
      rdy_q      <= !sk_vld_nxt;
      if (accept) begin
        sat_count <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
      end
      if (out_fire && main_q.last) begin
        frame_count <= frame_count + 32'd1;
      end
    end
  end

  assign s_axis.tready = rdy_q;
  assign m_axis.tvalid = main_vld_q;
  assign m_axis.tdata  = main_q.dat;
  assign m_axis.tlast  = main_q.last;

endmodule

// File: tb/tb_ldpc_llr_noise_injector.sv
// Randomised bench for ldpc_llr_noise_injector against a queue-based behavioural channel model.
module tb_ldpc_llr_noise_injector;

  localparam logic [31:0] SEED = 32'h0000ACE1;

  logic        data_clk = 1'b0;
  logic        data_resetn = 1'b0;
  logic        en = 1'b0;
  logic        load_seed = 1'b0;
  logic [2:0]  noise_shift = 3'd0;
  logic [31:0] sat_count;
  logic [31:0] frame_count;

  ldpc_llr_noise_injector_if s_axis ();
  ldpc_llr_noise_injector_if m_axis ();

  always #5 data_clk = ~data_clk;

  ldpc_llr_noise_injector #(
    .SEED  (SEED),
    .LANES (16)
  ) dut (
    .data_clk    (data_clk),
    .data_resetn (data_resetn),
    .en          (en),
    .noise_shift (noise_shift),
    .load_seed   (load_seed),
    .s_axis      (s_axis),
    .m_axis      (m_axis),
    .sat_count   (sat_count),
    .frame_count (frame_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [127:0] dat;
    logic         last;
  } exp_t;

  logic [31:0]       mdl_lfsr [16];
  longint unsigned   mdl_sat;
  logic [31:0]       mdl_frames;
  exp_t              exp_q [$];
  logic [127:0]      obs_q [$];
  int                acc_cnt;
  exp_t              mon_e;
  int                mon_ns;
  logic              hold_v;
  logic [127:0]      hold_d;
  logic              hold_l;

  function automatic logic [31:0] seed_of(int i);
    logic [31:0] s;
    s = SEED + 32'(i) * 32'h9E3779B9;
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] adv(logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic void noisy_beat(input logic [127:0] d, input int sh,
                                     output logic [127:0] o, output int nsat);
    int llr, raw, n, sum, clip;
    logic [7:0] b;
    nsat = 0;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      b    = d[8*i +: 8];
      llr  = int'($signed(b));
      b    = mdl_lfsr[i][7:0];
      raw  = int'($signed(b));
      n    = raw >>> sh;
      sum  = llr + n;
      clip = (sum > 127) ? 127 : ((sum < -127) ? -127 : sum);
      if (clip != sum) nsat++;
      o[8*i +: 8] = 8'(clip);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl_lfsr[i] = seed_of(i);
    mdl_sat    = 0;
    mdl_frames = 0;
    exp_q.delete();
  endtask

  // Monitor: sampled mid-cycle, it sees exactly what the next rising edge will act on.
  always @(negedge data_clk) begin
    if (!data_resetn) begin
      model_reset();
      hold_v = 1'b0;
    end else begin
      chk("sat_count", 128'(sat_count), 128'(mdl_sat));
      chk("frame_count", 128'(frame_count), 128'(mdl_frames));
      if (hold_v) begin
        chk("hold_vld", 128'(m_axis.tvalid), 128'(1));
        chk("hold_dat", m_axis.tdata, hold_d);
        chk("hold_last", 128'(m_axis.tlast), 128'(hold_l));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        obs_q.push_back(m_axis.tdata);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(1), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_dat", m_axis.tdata, mon_e.dat);
          chk("out_last", 128'(m_axis.tlast), 128'(mon_e.last));
          if (mon_e.last) mdl_frames = mdl_frames + 32'd1;
        end
      end
      hold_v = m_axis.tvalid && !m_axis.tready;
      hold_d = m_axis.tdata;
      hold_l = m_axis.tlast;
      if (s_axis.tvalid && s_axis.tready) begin
        acc_cnt++;
        mon_e.last = s_axis.tlast;
        if (en) begin
          noisy_beat(s_axis.tdata, int'(noise_shift), mon_e.dat, mon_ns);
          mdl_sat = mdl_sat + longint'(mon_ns);
          if (mdl_sat > 64'hFFFF_FFFF) mdl_sat = 64'hFFFF_FFFF;
          for (int i = 0; i < 16; i++) mdl_lfsr[i] = adv(mdl_lfsr[i]);
        end else begin
          mon_e.dat = s_axis.tdata;
        end
        exp_q.push_back(mon_e);
      end
      if (load_seed) begin
        for (int i = 0; i < 16; i++) mdl_lfsr[i] = seed_of(i);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] d, input logic l);
    int   t;
    logic acc;
    t = 0;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    forever begin
      acc = s_axis.tready;
      @(posedge data_clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 128'(1), 128'(0));
        break;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    s_axis.tvalid  = 1'b0;
    m_axis.tready  = 1'b1;
    while ((exp_q.size() != 0 || m_axis.tvalid) && t < 300) begin
      @(posedge data_clk);
      #1;
      t++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic pulse_load();
    load_seed = 1'b1;
    @(posedge data_clk);
    #1;
    load_seed = 1'b0;
  endtask

  function automatic logic [127:0] rnd_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  logic [127:0] lane_idx;
  logic [127:0] rep_in [20];
  logic [127:0] rep_out [$];
  logic [31:0]  sat_before;
  logic [31:0]  frames_before;
  bit           rnd_done;

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b0;
    acc_cnt       = 0;
    for (int i = 0; i < 16; i++) lane_idx[8*i +: 8] = 8'(i);

    // Reset values and ready rising on first edge after release.
    repeat (3) @(posedge data_clk);
    #1;
    chk("rst_s_rdy", 128'(s_axis.tready), 128'(0));
    chk("rst_m_vld", 128'(m_axis.tvalid), 128'(0));
    chk("rst_m_dat", m_axis.tdata, 128'(0));
    chk("rst_m_last", 128'(m_axis.tlast), 128'(0));
    chk("rst_sat", 128'(sat_count), 128'(0));
    chk("rst_frame", 128'(frame_count), 128'(0));
    data_resetn = 1'b1;
    #1;
    chk("rel_rdy_low", 128'(s_axis.tready), 128'(0));
    @(posedge data_clk);
    #1;
    chk("rel_rdy_high", 128'(s_axis.tready), 128'(1));

    // Bypass.
    m_axis.tready = 1'b1;
    en = 1'b0;
    noise_shift = 3'd0;
    send(lane_idx, 1'b0);
    chk("lat_vld", 128'(m_axis.tvalid), 128'(1));
    chk("lat_dat", m_axis.tdata, lane_idx);
    for (int k = 1; k < 8; k++) send(lane_idx, k == 7);
    drain();
    chk("bypass_sat", 128'(sat_count), 128'(0));

    // Clip at the negative bound.
    en = 1'b1;
    noise_shift = 3'd7;
    for (int k = 0; k < 4; k++) send(fill(8'h81), 1'b0);
    drain();
    chk("clip_sat", 128'(sat_count), 128'(mdl_sat));

    // Positive bound never saturates with shift 7.
    sat_before = 32'(mdl_sat);
    for (int k = 0; k < 4; k++) send(fill(8'h7F), 1'b0);
    drain();
    chk("pos_sat_same", 128'(sat_count), 128'(sat_before));

    // Randomised traffic with random downstream stalls.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          en          = ($urandom_range(0, 4) != 0);
          noise_shift = 3'($urandom_range(0, 7));
          load_seed   = ($urandom_range(0, 15) == 0);
          case ($urandom_range(0, 5))
            0:       send(fill(8'h80), 1'($urandom_range(0, 1)));
            1:       send(fill(8'h81), 1'($urandom_range(0, 1)));
            2:       send(fill(8'h7F), 1'($urandom_range(0, 1)));
            default: send(rnd_beat(), 1'($urandom_range(0, 1)));
          endcase
          load_seed = 1'b0;
        end
        s_axis.tvalid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge data_clk);
          #1;
          m_axis.tready = ($urandom_range(0, 3) != 0);
        end
        m_axis.tready = 1'b1;
      end
    join
    drain();

    // Backpressure: exactly two beats absorbed while output stalls.
    en = 1'b1;
    noise_shift = 3'd1;
    m_axis.tready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(rnd_beat(), k == 5);
        s_axis.tvalid = 1'b0;
      end
      begin
        repeat (10) @(posedge data_clk);
        #1;
        chk("bp_held", 128'(acc_cnt), 128'(2));
        chk("bp_rdy_low", 128'(s_axis.tready), 128'(0));
        m_axis.tready = 1'b1;
      end
    join
    drain();
    chk("bp_total", 128'(acc_cnt), 128'(6));

    // Three frames of four beats.
    frames_before = mdl_frames;
    for (int k = 0; k < 12; k++) send(rnd_beat(), (k % 4) == 3);
    drain();
    chk("frame3", 128'(frame_count), 128'(frames_before + 32'd3));

    // Reproducibility after a seed reload.
    noise_shift = 3'd2;
    for (int k = 0; k < 20; k++) rep_in[k] = rnd_beat();
    pulse_load();
    obs_q.delete();
    for (int k = 0; k < 20; k++) send(rep_in[k], (k % 4) == 3);
    drain();
    rep_out = obs_q;
    pulse_load();
    obs_q.delete();
    for (int k = 0; k < 20; k++) send(rep_in[k], (k % 4) == 3);
    drain();
    chk("repro_len", 128'(obs_q.size()), 128'(20));
    for (int k = 0; k < 20 && k < obs_q.size() && k < rep_out.size(); k++)
      chk($sformatf("repro_%0d", k), obs_q[k], rep_out[k]);

    // Reset with two beats in flight.
    noise_shift = 3'd0;
    m_axis.tready = 1'b0;
    send(rnd_beat(), 1'b0);
    send(rnd_beat(), 1'b0);
    s_axis.tvalid = 1'b0;
    data_resetn = 1'b0;
    #2;
    chk("mid_rst_vld", 128'(m_axis.tvalid), 128'(0));
    chk("mid_rst_dat", m_axis.tdata, 128'(0));
    chk("mid_rst_last", 128'(m_axis.tlast), 128'(0));
    chk("mid_rst_rdy", 128'(s_axis.tready), 128'(0));
    chk("mid_rst_sat", 128'(sat_count), 128'(0));
    chk("mid_rst_frame", 128'(frame_count), 128'(0));
    @(posedge data_clk);
    #1;
    data_resetn = 1'b1;
    @(posedge data_clk);
    #1;
    chk("post_rst_rdy", 128'(s_axis.tready), 128'(1));
    m_axis.tready = 1'b1;
    obs_q.delete();
    send(lane_idx, 1'b1);
    drain();
    chk("post_rst_beats", 128'(obs_q.size()), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
